proc_pipe_param: RTL and testbench

Parametrised three-stage pipelined processor (IF, ID, EX/WB) with EX/WB-to-EX forwarding, write-through register file, IF-stage jumps and a run/hold control. It generalises the team's fixed 8-bit core in data width, register count and PC width, and adds an immediate load, more ALU ops, a hard-wired zero register and a writeback observation port. Instruction memory is external to the block so benches and SoC wrappers can drive it.

---
 rtl/proc_pipe_param.sv | 180 ++++++++++++++++++
 tb/tb_proc_pipe_param.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_pipe_param.sv
// Three-stage (IF, ID, EX/WB) parametrised processor with EX/WB-to-EX forwarding,
// a write-through register file, zero-penalty IF-stage jumps and a run/hold control.
module proc_pipe_param #(
  parameter int DATA_W = 8,
  parameter int RA_W   = 3,
  parameter int PC_W   = 8,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  output logic [PC_W-1:0]       imem_addr,
  input  logic [3+2*RA_W-1:0]   imem_data,
  output logic                  wb_valid,
  output logic [RA_W-1:0]       wb_addr,
  output logic [DATA_W-1:0]     wb_data,
  output logic [CNT_W-1:0]      retire_cnt
);

  localparam int INSTR_W = 3 + 2*RA_W;
  localparam int NREG    = 1 << RA_W;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_LI  = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  // Low PC bits replaced by the jump field; upper bits come from PC+1.
  localparam logic [PC_W-1:0] JMP_MASK = PC_W'((64'd1 << (2*RA_W)) - 64'd1);

  function automatic logic signed [DATA_W-1:0] alu(
    input logic        [2:0]        op,
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b,
    input logic        [RA_W-1:0]   imm
  );
    logic signed [DATA_W-1:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_LI:   r = DATA_W'(imm);
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [PC_W-1:0]             pc_q, pc_d, pc_inc;
  logic [2:0]                  if_op;
  logic [INSTR_W-1:0]          instr_p0_q;

  logic [2:0]                  op_id;
  logic [RA_W-1:0]             rs1_id, rs2_id;
  logic                        vld_p1_d;
  logic signed [DATA_W-1:0]    opa_p1_d, opb_p1_d;

  logic [2:0]                  op_p1_q;
  logic [RA_W-1:0]             rs1a_p1_q, rd_p1_q;
  logic                        vld_p1_q;
  logic signed [DATA_W-1:0]    opa_p1_q, opb_p1_q;

  logic                        fwd_a, fwd_b;
  logic signed [DATA_W-1:0]    a_ex, b_ex, res_p2_d;

  logic                        vld_p2_q;
  logic [RA_W-1:0]             rd_p2_q;
  logic signed [DATA_W-1:0]    res_p2_q;

  logic signed [DATA_W-1:0]    rf_q [NREG];
  logic [CNT_W-1:0]            cnt_q, cnt_d;

  // ---- IF: next PC, jumps resolved from the fetched word ----
  assign imem_addr = pc_q;
  assign if_op     = imem_data[INSTR_W-1:2*RA_W];
  assign pc_inc    = pc_q + PC_W'(1);

  always_comb begin
    pc_d = pc_inc;
    if (if_op == OP_JMP)
      pc_d = (pc_inc & ~JMP_MASK) | PC_W'(imem_data[2*RA_W-1:0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= '0;
      instr_p0_q <= '0;
    end else if (run) begin
      pc_q       <= pc_d;
      instr_p0_q <= imem_data;
    end
  end

  // ---- ID: decode and register read with write-through ----
  assign op_id    = instr_p0_q[INSTR_W-1:2*RA_W];
  assign rs1_id   = instr_p0_q[2*RA_W-1:RA_W];
  assign rs2_id   = instr_p0_q[RA_W-1:0];
  assign vld_p1_d = (op_id != OP_NOP) && (op_id != OP_JMP);

  always_comb begin
    opa_p1_d = rf_q[rs1_id];
    if (rs1_id == '0)
      opa_p1_d = '0;
    else if (wb_valid && (wb_addr == rs1_id))
      opa_p1_d = res_p2_q;
    opb_p1_d = rf_q[rs2_id];
    if (rs2_id == '0)
      opb_p1_d = '0;
    else if (wb_valid && (wb_addr == rs2_id))
      opb_p1_d = res_p2_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_p1_q  <= OP_NOP;
      rd_p1_q  <= '0;
      vld_p1_q <= 1'b0;
    end else if (run) begin
      op_p1_q  <= op_id;
      rd_p1_q  <= rs2_id;
      vld_p1_q <= vld_p1_d;
    end
  end

  // Operand values are meaningless while the stage holds a NOP.
  always_ff @(posedge clk) begin
    if (run) begin
      rs1a_p1_q <= rs1_id;
      opa_p1_q  <= opa_p1_d;
      opb_p1_q  <= opb_p1_d;
    end
  end

  // ---- EX: forwarding from EX/WB (never from r0) and ALU ----
  assign fwd_a    = vld_p2_q && (rd_p2_q != '0) && (rd_p2_q == rs1a_p1_q);
  assign fwd_b    = vld_p2_q && (rd_p2_q != '0) && (rd_p2_q == rd_p1_q);
  assign a_ex     = fwd_a ? res_p2_q : opa_p1_q;
  assign b_ex     = fwd_b ? res_p2_q : opb_p1_q;
  assign res_p2_d = alu(op_p1_q, a_ex, b_ex, rs1a_p1_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p2_q <= 1'b0;
      rd_p2_q  <= '0;
      res_p2_q <= '0;
    end else if (run) begin
      vld_p2_q <= vld_p1_q;
      rd_p2_q  <= rd_p1_q;
      res_p2_q <= res_p2_d;
    end
  end

  // ---- WB: register file write and retire counter ----
  assign wb_valid   = vld_p2_q && (rd_p2_q != '0) && run;
  assign wb_addr    = rd_p2_q;
  assign wb_data    = res_p2_q;
  assign retire_cnt = cnt_q;
  assign cnt_d      = cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (wb_valid) begin
      rf_q[wb_addr] <= res_p2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= '0;
    else if (wb_valid)
      cnt_q <= cnt_d;
  end

endmodule

// File: tb/tb_proc_pipe_param.sv
// Bench for proc_pipe_param: an in-order ISA model predicts every writeback, PC and
// retire count; directed programs add hand-computed literal expectations.
module tb_proc_pipe_param;

  localparam int DATA_W = 8, RA_W = 3, PC_W = 8, CNT_W = 16, INSTR_W = 9;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                run = 1'b1;
  logic [PC_W-1:0]     imem_addr;
  logic [INSTR_W-1:0]  imem_data;
  logic                wb_valid;
  logic [RA_W-1:0]     wb_addr;
  logic [DATA_W-1:0]   wb_data;
  logic [CNT_W-1:0]    retire_cnt;

  logic [INSTR_W-1:0]  imem [256];
  assign imem_data = imem[imem_addr];

  proc_pipe_param #(.DATA_W(DATA_W), .RA_W(RA_W), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .run(run),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  bit chk_en = 1'b0;
  bit ev;

  // Architectural model: executes each instruction at fetch; writebacks delayed 3 active cycles.
  int m_pc = 0, m_cnt = 0, cyc = 0;
  int m_regs [8];
  int p_v [3], p_a [3], p_d [3];
  int obs_a [$], obs_d [$], obs_c [$], addr_q [$];

  function automatic logic [8:0] enc(int op, int a, int b);
    return {op[2:0], a[2:0], b[2:0]};
  endfunction

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [8:0] ins;
    int op, a, b, x, y, res;
    bit wr;
    if (reset) begin
      m_pc = 0; m_cnt = 0; cyc = 0;
      for (int i = 0; i < 8; i++) m_regs[i] = 0;
      for (int i = 0; i < 3; i++) begin p_v[i] = 0; p_a[i] = 0; p_d[i] = 0; end
    end else begin
      cyc++;
      if (run) begin
        if (p_v[2] != 0) m_cnt = (m_cnt + 1) % 65536;
        ins = imem[m_pc];
        op = int'(ins[8:6]); a = int'(ins[5:3]); b = int'(ins[2:0]);
        x = (a == 0) ? 0 : m_regs[a];
        y = (b == 0) ? 0 : m_regs[b];
        case (op)
          1: res = (x + y) % 256;
          2: res = (x - y + 256) % 256;
          3: res = x & y;
          4: res = x | y;
          5: res = x ^ y;
          6: res = a;
          default: res = 0;
        endcase
        wr = (op >= 1) && (op <= 6) && (b != 0);
        if (wr) m_regs[b] = res;
        p_v[2] = p_v[1]; p_a[2] = p_a[1]; p_d[2] = p_d[1];
        p_v[1] = p_v[0]; p_a[1] = p_a[0]; p_d[1] = p_d[0];
        p_v[0] = int'(wr); p_a[0] = b; p_d[0] = res;
        if (op == 7) m_pc = (((m_pc + 1) % 256) & 32'hC0) | int'(ins[5:0]);
        else         m_pc = (m_pc + 1) % 256;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      ev = (p_v[2] != 0) && run;
      chk("imem_addr", int'(imem_addr), m_pc);
      chk("wb_valid", int'(wb_valid), int'(ev));
      if (ev && wb_valid) begin
        chk("wb_addr", int'(wb_addr), p_a[2]);
        chk("wb_data", int'(wb_data), p_d[2]);
      end
      chk("retire_cnt", int'(retire_cnt), m_cnt);
      if (wb_valid) begin
        obs_a.push_back(int'(wb_addr));
        obs_d.push_back(int'(wb_data));
        obs_c.push_back(cyc + 1);
      end
      addr_q.push_back(int'(imem_addr));
    end
  end

  task automatic step(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = '0;
  endtask

  task automatic begin_reset();
    reset = 1'b1; run = 1'b1;
    clear_imem();
  endtask

  task automatic release_reset();
    step(1);
    reset = 1'b0;
    obs_a.delete(); obs_d.delete(); obs_c.delete(); addr_q.delete();
  endtask

  task automatic obs_is(string name, int idx, int a, int d, int c);
    if (idx >= obs_a.size()) begin
      chk({name, "_count"}, obs_a.size(), idx + 1);
    end else begin
      chk({name, "_addr"}, obs_a[idx], a);
      chk({name, "_data"}, obs_d[idx], d);
      chk({name, "_cycle"}, obs_c[idx], c);
    end
  endtask

  task automatic addr_is(string name, int idx, int pc);
    if (idx >= addr_q.size()) chk({name, "_count"}, addr_q.size(), idx + 1);
    else                      chk(name, addr_q[idx], pc);
  endtask

  int exp_pc [14];

  initial begin
    clear_imem();
    step(2);
    @(negedge clk);
    chk("rst_imem_addr", int'(imem_addr), 0);
    chk("rst_wb_valid", int'(wb_valid), 0);
    chk("rst_wb_addr", int'(wb_addr), 0);
    chk("rst_wb_data", int'(wb_data), 0);
    chk("rst_retire", int'(retire_cnt), 0);
    chk_en = 1'b1;
    step(1);

    // Back-to-back LI/LI/ADD with distance-1 forwarding
    begin_reset();
    imem[0] = enc(6, 5, 1); imem[1] = enc(6, 3, 2); imem[2] = enc(1, 1, 2);
    release_reset();
    step(8);
    obs_is("t1_w0", 0, 1, 5, 4);
    obs_is("t1_w1", 1, 2, 3, 5);
    obs_is("t1_w2", 2, 2, 8, 6);
    chk("t1_retire", int'(retire_cnt), 3);
    chk("t1_model_r2", m_regs[2], 8);

    // Write-through (distance 2), forwarding, and SUB wrap-around
    begin_reset();
    imem[0] = enc(6, 6, 1); imem[1] = enc(6, 2, 2); imem[2] = enc(0, 0, 0);
    imem[3] = enc(2, 1, 2); imem[4] = enc(2, 1, 2); imem[5] = enc(6, 0, 3);
    imem[6] = enc(2, 3, 1);
    release_reset();
    step(12);
    obs_is("t2_w0", 0, 1, 6, 4);
    obs_is("t2_w1", 1, 2, 2, 5);
    obs_is("t2_sub_wt", 2, 2, 4, 7);
    obs_is("t2_sub_fwd", 3, 2, 2, 8);
    obs_is("t2_li0", 4, 3, 0, 9);
    obs_is("t2_wrap", 5, 1, 250, 10);
    chk("t2_retire", int'(retire_cnt), 6);
    chk("t2_model_r1", m_regs[1], 250);

    // r0: writes ignored, reads zero, never forwarded or written through
    begin_reset();
    imem[0] = enc(6, 4, 1); imem[3] = enc(6, 7, 0); imem[4] = enc(1, 0, 1);
    imem[5] = enc(1, 0, 1); imem[6] = enc(1, 1, 0);
    release_reset();
    step(12);
    obs_is("t3_w0", 0, 1, 4, 4);
    obs_is("t3_nofwd_r0", 1, 1, 4, 8);
    obs_is("t3_nowt_r0", 2, 1, 4, 9);
    chk("t3_count", obs_a.size(), 3);
    chk("t3_retire", int'(retire_cnt), 3);

    // Jump chain through every upper-PC page, wrapping from 0xFF
    begin_reset();
    imem[8'h05] = enc(7, 2, 2);
    imem[8'h12] = enc(6, 3, 5);
    imem[8'h13] = enc(7, 7, 7);
    imem[8'h3F] = enc(7, 7, 7);
    imem[8'h7F] = enc(7, 7, 7);
    imem[8'hBF] = enc(7, 7, 7);
    imem[8'hFF] = enc(7, 0, 5);
    release_reset();
    step(14);
    exp_pc = '{0, 1, 2, 3, 4, 5, 'h12, 'h13, 'h3F, 'h7F, 'hBF, 'hFF, 'h05, 'h12};
    for (int i = 0; i < 14; i++) addr_is($sformatf("t4_pc%0d", i), i, exp_pc[i]);
    obs_is("t4_li", 0, 5, 3, 10);
    chk("t4_model_r5", m_regs[5], 3);

    // run held low for 3 cycles with LI r1,5 in EX/WB
    begin_reset();
    imem[0] = enc(6, 5, 1); imem[1] = enc(6, 7, 2); imem[2] = enc(1, 1, 2);
    imem[3] = enc(2, 2, 1);
    release_reset();
    step(3);
    run = 1'b0;
    step(3);
    run = 1'b1;
    step(8);
    for (int i = 3; i < 7; i++) addr_is($sformatf("t5_hold_pc%0d", i), i, 3);
    addr_is("t5_resume_pc", 7, 4);
    obs_is("t5_w0", 0, 1, 5, 7);
    obs_is("t5_w1", 1, 2, 7, 8);
    obs_is("t5_w2", 2, 2, 12, 9);
    obs_is("t5_w3", 3, 1, 7, 10);
    chk("t5_count", obs_a.size(), 4);
    chk("t5_retire", int'(retire_cnt), 4);

    // Reset mid-program discards in-flight work and clears registers
    begin_reset();
    imem[0] = enc(6, 5, 1); imem[1] = enc(6, 6, 2);
    imem[6] = enc(6, 1, 3); imem[7] = enc(6, 2, 4);
    release_reset();
    step(8);
    chk("t6_pre_retire", int'(retire_cnt), 2);
    obs_is("t6_pre_w1", 1, 2, 6, 5);
    reset = 1'b1;
    clear_imem();
    imem[0] = enc(1, 1, 2); imem[1] = enc(1, 3, 4);
    step(1);
    reset = 1'b0;
    obs_a.delete(); obs_d.delete(); obs_c.delete(); addr_q.delete();
    @(negedge clk);
    chk("t6_post_pc", int'(imem_addr), 0);
    chk("t6_post_retire", int'(retire_cnt), 0);
    step(6);
    obs_is("t6_r2_zero", 0, 2, 0, 4);
    obs_is("t6_r4_zero", 1, 4, 0, 5);
    chk("t6_count", obs_a.size(), 2);
    chk("t6_retire", int'(retire_cnt), 2);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
